// File: rtl/ps2_lane_key_decoder.sv
// PS/2 set-2 byte stream to per-lane press/release events, held bitmap and BCD press count.
module ps2_lane_key_decoder #(
    parameter logic [7:0]  KEY_CODE_0     = 8'h1C,
    parameter logic [7:0]  KEY_CODE_1     = 8'h1B,
    parameter logic [7:0]  KEY_CODE_2     = 8'h23,
    parameter logic [7:0]  KEY_CODE_3     = 8'h2B,
    parameter int unsigned PREFIX_TIMEOUT = 100000,
    parameter int unsigned TO_W           = 17
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic [3:0] lane_press,
    output logic [3:0] lane_release,
    output logic [3:0] lane_held,
    output logic       event_valid,
    output logic [1:0] last_lane,
    output logic [3:0] press_ones,
    output logic [3:0] press_tens
);

    localparam logic [7:0]      BREAK_CODE = 8'hF0;
    localparam logic [7:0]      EXT_CODE   = 8'hE0;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [3:0]      held_q, held_d;
    logic [3:0]      press_q, press_d;
    logic [3:0]      release_q, release_d;
    logic            event_q, event_d;
    logic [1:0]      last_q, last_d;
    logic [3:0]      ones_q, ones_d;
    logic [3:0]      tens_q, tens_d;

    logic            lane_hit_c;
    logic [1:0]      lane_idx_c;

    // Map the incoming byte to a lane index
    always_comb begin
        lane_hit_c = 1'b1;
        lane_idx_c = 2'd0;
        if (ps2_key_data == KEY_CODE_0) begin
            lane_idx_c = 2'd0;
        end else if (ps2_key_data == KEY_CODE_1) begin
            lane_idx_c = 2'd1;
        end else if (ps2_key_data == KEY_CODE_2) begin
            lane_idx_c = 2'd2;
        end else if (ps2_key_data == KEY_CODE_3) begin
            lane_idx_c = 2'd3;
        end else begin
            lane_hit_c = 1'b0;
        end
    end

    // Sequence parser, lane actions, press counter and prefix timeout
    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        held_d    = held_q;
        press_d   = 4'b0000;
        release_d = 4'b0000;
        last_d    = last_q;
        ones_d    = ones_q;
        tens_d    = tens_q;

        if (ps2_key_pressed) begin
            to_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == BREAK_CODE) begin
                        state_d = S_BREAK;
                    end else if (ps2_key_data == EXT_CODE) begin
                        state_d = S_EXT;
                    end else if (lane_hit_c && !held_q[lane_idx_c]) begin
                        // Fresh make; repeats of a held key are typematic and dropped
                        held_d[lane_idx_c]  = 1'b1;
                        press_d[lane_idx_c] = 1'b1;
                        last_d              = lane_idx_c;
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = (tens_q == 4'd9) ? 4'd0 : 4'(tens_q + 4'd1);
                        end else begin
                            ones_d = 4'(ones_q + 4'd1);
                        end
                    end
                end
                S_BREAK: begin
                    if (lane_hit_c) begin
                        state_d = S_IDLE;
                        if (held_q[lane_idx_c]) begin
                            held_d[lane_idx_c]    = 1'b0;
                            release_d[lane_idx_c] = 1'b1;
                        end
                    end else if (ps2_key_data == BREAK_CODE) begin
                        state_d = S_BREAK;
                    end else if (ps2_key_data == EXT_CODE) begin
                        state_d = S_EXT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (ps2_key_data == BREAK_CODE) begin
                        state_d = S_EXT_BREAK;
                    end else if (ps2_key_data == EXT_CODE) begin
                        state_d = S_EXT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BREAK: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q == S_IDLE) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            // Abandon a prefix whose follow-up byte never arrived
            state_d = S_IDLE;
            to_d    = '0;
        end else begin
            to_d = TO_W'(to_q + TO_W'(1));
        end

        event_d = |press_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            to_q      <= '0;
            held_q    <= 4'b0000;
            press_q   <= 4'b0000;
            release_q <= 4'b0000;
            event_q   <= 1'b0;
            last_q    <= 2'd0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            event_q   <= event_d;
            last_q    <= last_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
        end
    end

    assign lane_press   = press_q;
    assign lane_release = release_q;
    assign lane_held    = held_q;
    assign event_valid  = event_q;
    assign last_lane    = last_q;
    assign press_ones   = ones_q;
    assign press_tens   = tens_q;

endmodule

// File: tb/tb_ps2_lane_key_decoder.sv
// Self-checking bench: hand vector table, directed corner sequences and random traffic vs an event-level model.
module tb_ps2_lane_key_decoder;

    localparam int unsigned TO   = 40;
    localparam int unsigned TO_W = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic [3:0] lane_press, lane_release, lane_held;
    logic       event_valid;
    logic [1:0] last_lane;
    logic [3:0] press_ones, press_tens;

    ps2_lane_key_decoder #(
        .KEY_CODE_0(8'h1C), .KEY_CODE_1(8'h1B), .KEY_CODE_2(8'h23), .KEY_CODE_3(8'h2B),
        .PREFIX_TIMEOUT(TO), .TO_W(TO_W)
    ) dut (
        .CLOCK_50(clk), .reset(reset),
        .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
        .lane_press(lane_press), .lane_release(lane_release), .lane_held(lane_held),
        .event_valid(event_valid), .last_lane(last_lane),
        .press_ones(press_ones), .press_tens(press_tens)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending-prefix flags, idle-gap length, held set and a decimal count
    bit [3:0] m_held, m_press, m_rel;
    bit [1:0] m_last;
    int       m_count;
    bit       m_pend_brk, m_pend_ext;
    int       m_gap;

    function automatic int lane_of(input logic [7:0] d);
        case (d)
            8'h1C:   return 0;
            8'h1B:   return 1;
            8'h23:   return 2;
            8'h2B:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input logic [7:0] d);
        int ln;
        m_press = '0;
        m_rel   = '0;
        if (r) begin
            m_held = '0; m_last = '0; m_count = 0;
            m_pend_brk = 0; m_pend_ext = 0; m_gap = 0;
        end else if (!s) begin
            m_gap++;
            if (m_gap >= int'(TO)) begin
                m_pend_brk = 0;
                m_pend_ext = 0;
            end
        end else begin
            m_gap = 0;
            ln = lane_of(d);
            if (m_pend_ext) begin
                if (m_pend_brk) begin
                    m_pend_brk = 0; m_pend_ext = 0;
                end else if (d == 8'hF0) begin
                    m_pend_brk = 1;
                end else if (d != 8'hE0) begin
                    m_pend_ext = 0;
                end
            end else if (m_pend_brk) begin
                if (ln >= 0) begin
                    if (m_held[ln]) begin
                        m_held[ln] = 0;
                        m_rel[ln]  = 1;
                    end
                    m_pend_brk = 0;
                end else if (d == 8'hE0) begin
                    m_pend_brk = 0; m_pend_ext = 1;
                end else if (d != 8'hF0) begin
                    m_pend_brk = 0;
                end
            end else begin
                if (d == 8'hF0) begin
                    m_pend_brk = 1;
                end else if (d == 8'hE0) begin
                    m_pend_ext = 1;
                end else if (ln >= 0 && !m_held[ln]) begin
                    m_held[ln]  = 1;
                    m_press[ln] = 1;
                    m_last      = 2'(ln);
                    m_count     = (m_count + 1) % 100;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({lane_press, lane_release, lane_held, event_valid, last_lane, press_tens, press_ones});
    endfunction

    function automatic logic [31:0] model_vec();
        logic [3:0] t, o;
        t = 4'(m_count / 10);
        o = 4'(m_count % 10);
        return 32'({m_press, m_rel, m_held, |m_press, m_last, t, o});
    endfunction

    // One clock: drive, let the edge happen, advance the model, compare just after the edge
    task automatic tick(input bit r, input bit s, input logic [7:0] d);
        reset           = r;
        ps2_key_pressed = s;
        ps2_key_data    = s ? d : 8'($urandom);
        @(posedge clk);
        model_step(r, s, d);
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00);
    endtask

    typedef struct {
        bit         rst;
        bit         stb;
        logic [7:0] data;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] held;
        logic [1:0] last;
        logic [7:0] bcd;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, logic [7:0] d, logic [3:0] p, logic [3:0] rl,
                                logic [3:0] h, logic [1:0] l, logic [7:0] b);
        vec_t v;
        v.rst = r; v.stb = s; v.data = d; v.press = p; v.rel = rl; v.held = h; v.last = l; v.bcd = b;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Single key make/break
        tbl.push_back(mk(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h1C, 4'b0001, 4'b0000, 4'b0001, 2'd0, 8'h01));
        tbl.push_back(mk(0, 0, 8'h00, 4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h01));
        tbl.push_back(mk(0, 1, 8'hF0, 4'b0000, 4'b0000, 4'b0001, 2'd0, 8'h01));
        tbl.push_back(mk(0, 1, 8'h1C, 4'b0000, 4'b0001, 4'b0000, 2'd0, 8'h01));
        tbl.push_back(mk(0, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd0, 8'h01));
        // Typematic repeats
        tbl.push_back(mk(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h1B, 4'b0010, 4'b0000, 4'b0010, 2'd1, 8'h01));
        tbl.push_back(mk(0, 1, 8'h1B, 4'b0000, 4'b0000, 4'b0010, 2'd1, 8'h01));
        tbl.push_back(mk(0, 1, 8'h1B, 4'b0000, 4'b0000, 4'b0010, 2'd1, 8'h01));
        tbl.push_back(mk(0, 1, 8'hF0, 4'b0000, 4'b0000, 4'b0010, 2'd1, 8'h01));
        tbl.push_back(mk(0, 1, 8'h1B, 4'b0000, 4'b0010, 4'b0000, 2'd1, 8'h01));
        // Chord of lanes 0 and 3
        tbl.push_back(mk(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h1C, 4'b0001, 4'b0000, 4'b0001, 2'd0, 8'h01));
        tbl.push_back(mk(0, 1, 8'h2B, 4'b1000, 4'b0000, 4'b1001, 2'd3, 8'h02));
        tbl.push_back(mk(0, 1, 8'hF0, 4'b0000, 4'b0000, 4'b1001, 2'd3, 8'h02));
        tbl.push_back(mk(0, 1, 8'h1C, 4'b0000, 4'b0001, 4'b1000, 2'd3, 8'h02));

        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].stb, tbl[i].data);
            chk($sformatf("table[%0d]", i),
                32'({lane_press, lane_release, lane_held, event_valid, last_lane, press_tens, press_ones}),
                32'({tbl[i].press, tbl[i].rel, tbl[i].held, |tbl[i].press, tbl[i].last, tbl[i].bcd}));
        end

        // Extended and orphan-break sequences have no lane effect
        tick(1, 0, 8'h00);
        tick(0, 1, 8'hE0); tick(0, 1, 8'h1C);
        tick(0, 1, 8'hE0); tick(0, 1, 8'hF0); tick(0, 1, 8'h1C);
        tick(0, 1, 8'hF0); tick(0, 1, 8'h23);
        chk("prefix_held", 32'(lane_held), 32'h0);
        chk("prefix_count", 32'({press_tens, press_ones}), 32'h00);

        // Timeout expired: the byte after a stale F0 is a make
        tick(0, 1, 8'hF0);
        idle(TO);
        tick(0, 1, 8'h23);
        chk("timeout_make", 32'(lane_press), 32'b0100);

        // One cycle short of the timeout: the strobe still completes the break
        tick(0, 1, 8'hF0);
        idle(TO - 1);
        tick(0, 1, 8'h23);
        chk("timeout_edge_release", 32'(lane_release), 32'b0100);
        chk("timeout_edge_held", 32'(lane_held), 32'h0);

        // Counter wrap across 09->10 and 99->00
        tick(1, 0, 8'h00);
        for (int i = 1; i <= 100; i++) begin
            tick(0, 1, 8'h2B);
            if (i == 9)   chk("bcd_09", 32'({press_tens, press_ones}), 32'h09);
            if (i == 10)  chk("bcd_10", 32'({press_tens, press_ones}), 32'h10);
            if (i == 99)  chk("bcd_99", 32'({press_tens, press_ones}), 32'h99);
            if (i == 100) chk("bcd_00", 32'({press_tens, press_ones}), 32'h00);
            tick(0, 1, 8'hF0);
            tick(0, 1, 8'h2B);
        end

        // Reset in the middle of a break sequence
        tick(1, 0, 8'h00);
        tick(0, 1, 8'h1C); tick(0, 1, 8'h1B); tick(0, 1, 8'hF0);
        tick(1, 0, 8'h00);
        chk("rst_mid_held", 32'(lane_held), 32'h0);
        chk("rst_mid_release", 32'(lane_release), 32'h0);
        chk("rst_mid_count", 32'({press_tens, press_ones}), 32'h00);
        tick(0, 1, 8'h1C);
        chk("rst_mid_press", 32'(lane_press), 32'b0001);
        chk("rst_mid_count1", 32'({press_tens, press_ones}), 32'h01);

        // Random traffic, including long silences across the timeout and rare resets
        begin
            logic [7:0] codes [12];
            codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'hE0, 8'hF0, 8'hAA,
                      8'hFA, 8'hE1, 8'h12, 8'h1C};
            for (int n = 0; n < 4000; n++) begin
                int unsigned roll;
                roll = $urandom_range(0, 999);
                if (roll < 2) begin
                    tick(1, 1'($urandom), 8'h1C);
                end else if (roll < 25) begin
                    idle(int'($urandom_range(TO - 3, TO + 3)));
                end else if (roll < 500) begin
                    tick(0, 1, codes[$urandom_range(0, 11)]);
                end else begin
                    tick(0, 0, 8'h00);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
